// File: rtl/tcp_rx_decoder_pkg.sv
// Shared types and constants for the TCP receive-side segment decoder and
// the server FSM that consumes its descriptors.
package tcp_rx_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPT,
        PAY,
        OUT,
        DROP
    } tcp_rx_state_t;

    // Bit positions inside seg_flags, matching the TCP header flag byte.
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;

    localparam int         HDR_BYTES = 20;
    localparam logic [3:0] MIN_DOFF  = 4'd5;

    typedef struct packed {
        logic [5:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] win;
        logic [15:0] len;
        logic        oversize;
    } tcp_seg_desc_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] a);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, a};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/tcp_rx_segment_decoder.sv
// Parses a received TCP segment byte stream, drops malformed or foreign-port
// segments and presents one descriptor per accepted segment.
module tcp_rx_segment_decoder #(
    parameter logic [15:0] LOCAL_PORT  = 16'd80,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1460
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        seg_vld,
    input  logic        seg_rdy,
    output logic [5:0]  seg_flags,
    output logic [31:0] seg_seq,
    output logic [31:0] seg_ack,
    output logic [15:0] seg_win,
    output logic [15:0] seg_len,
    output logic        seg_oversize,
    output logic [15:0] drop_cnt
);
    import tcp_rx_decoder_pkg::*;

    tcp_rx_state_t state_reg, state_next;
    logic [4:0]    byte_cnt_reg, byte_cnt_next;
    logic [5:0]    opt_cnt_reg, opt_cnt_next;
    logic [15:0]   len_reg, len_next;
    logic [15:0]   dport_reg;
    logic [31:0]   seq_reg, ack_reg;
    logic [3:0]    doff_reg;
    logic [5:0]    flags_reg;
    logic [15:0]   win_reg;
    tcp_seg_desc_t desc_reg;
    logic          seg_vld_reg;
    logic [15:0]   drop_cnt_reg;

    logic       acc;
    logic       hdr_capture;
    logic       hdr_last;
    logic       hdr_bad;
    logic       load_desc;
    logic [1:0] drop_add;

    assign in_rdy      = !rst && (state_reg != OUT);
    assign acc         = in_vld && in_rdy;
    assign hdr_capture = acc && (state_reg == HDR) && !in_sop;
    assign hdr_last    = (byte_cnt_reg == 5'(HDR_BYTES - 1));
    assign hdr_bad     = (dport_reg != LOCAL_PORT) || (doff_reg < MIN_DOFF);

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        opt_cnt_next  = opt_cnt_reg;
        len_next      = len_reg;
        load_desc     = 1'b0;
        drop_add      = 2'd0;
        if (state_reg == OUT) begin
            if (seg_vld_reg && seg_rdy)
                state_next = IDLE;
        end else if (acc) begin
            if (in_sop && state_reg != IDLE) begin
                // Abort: the interrupted segment is a drop; a sop+eop restart is a second one.
                if (in_eop) begin
                    drop_add   = 2'd2;
                    state_next = IDLE;
                end else begin
                    drop_add      = 2'd1;
                    byte_cnt_next = 5'd1;
                    state_next    = HDR;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (in_sop) begin
                            if (in_eop) begin
                                drop_add = 2'd1;
                            end else begin
                                byte_cnt_next = 5'd1;
                                state_next    = HDR;
                            end
                        end
                    end
                    HDR: begin
                        if (hdr_last) begin
                            len_next = 16'd0;
                            if (hdr_bad) begin
                                if (in_eop) begin
                                    drop_add   = 2'd1;
                                    state_next = IDLE;
                                end else begin
                                    state_next = DROP;
                                end
                            end else if (in_eop) begin
                                load_desc  = 1'b1;
                                state_next = OUT;
                            end else if (doff_reg > MIN_DOFF) begin
                                opt_cnt_next = {doff_reg - MIN_DOFF, 2'b00};
                                state_next   = OPT;
                            end else begin
                                state_next = PAY;
                            end
                        end else if (in_eop) begin
                            drop_add   = 2'd1;
                            state_next = IDLE;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 5'd1;
                        end
                    end
                    OPT: begin
                        len_next = 16'd0;
                        if (opt_cnt_reg == 6'd1) begin
                            if (in_eop) begin
                                load_desc  = 1'b1;
                                state_next = OUT;
                            end else begin
                                state_next = PAY;
                            end
                        end else if (in_eop) begin
                            drop_add   = 2'd1;
                            state_next = IDLE;
                        end else begin
                            opt_cnt_next = opt_cnt_reg - 6'd1;
                        end
                    end
                    PAY: begin
                        len_next = sat_add16(len_reg, 2'd1);
                        if (in_eop) begin
                            load_desc  = 1'b1;
                            state_next = OUT;
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            drop_add   = 2'd1;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= 5'd0;
            opt_cnt_reg  <= 6'd0;
            len_reg      <= 16'd0;
            dport_reg    <= 16'd0;
            seq_reg      <= 32'd0;
            ack_reg      <= 32'd0;
            doff_reg     <= 4'd0;
            flags_reg    <= 6'd0;
            win_reg      <= 16'd0;
            desc_reg     <= '0;
            seg_vld_reg  <= 1'b0;
            drop_cnt_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            opt_cnt_reg  <= opt_cnt_next;
            len_reg      <= len_next;
            drop_cnt_reg <= sat_add16(drop_cnt_reg, drop_add);
            // Big-endian fields: shift each new byte in at the LSB end.
            if (hdr_capture) begin
                case (byte_cnt_reg)
                    5'd2, 5'd3:                dport_reg <= {dport_reg[7:0], in_data};
                    5'd4, 5'd5, 5'd6, 5'd7:    seq_reg   <= {seq_reg[23:0], in_data};
                    5'd8, 5'd9, 5'd10, 5'd11:  ack_reg   <= {ack_reg[23:0], in_data};
                    5'd12:                     doff_reg  <= in_data[7:4];
                    5'd13:                     flags_reg <= in_data[5:0];
                    5'd14, 5'd15:              win_reg   <= {win_reg[7:0], in_data};
                    default: ;
                endcase
            end
            if (load_desc) begin
                desc_reg <= '{flags:    flags_reg,
                              seq:      seq_reg,
                              ack:      ack_reg,
                              win:      win_reg,
                              len:      len_next,
                              oversize: (len_next > MAX_PAYLOAD)};
                seg_vld_reg <= 1'b1;
            end else if (seg_vld_reg && seg_rdy) begin
                seg_vld_reg <= 1'b0;
            end
        end
    end

    assign seg_vld      = seg_vld_reg;
    assign seg_flags    = desc_reg.flags;
    assign seg_seq      = desc_reg.seq;
    assign seg_ack      = desc_reg.ack;
    assign seg_win      = desc_reg.win;
    assign seg_len      = desc_reg.len;
    assign seg_oversize = desc_reg.oversize;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: doc/tcp_rx_segment_decoder.md
Name: tcp_rx_segment_decoder

Overview:
Upstream stage of the TCP server protocol FSM. It consumes the received TCP segment as a byte stream (header first, network byte order) and drops segments that are malformed or addressed to another port. For each accepted segment it emits one decoded descriptor (flags, sequence, acknowledgement, window, payload length) over a valid/ready handshake. The server FSM uses each descriptor to select its next operation.

Parameters:
LOCAL_PORT, 16'd80, destination port accepted; all other ports are dropped.
MAX_PAYLOAD, 16'd1460, payload length above this value marks the descriptor oversize.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous reset, active-high.
in_vld  in  1  input byte valid.
in_rdy  out  1  decoder accepts a byte; transfer occurs when in_vld && in_rdy.
in_data  in  8  segment byte.
in_sop  in  1  first byte of segment.
in_eop  in  1  last byte of segment.
seg_vld  out  1  descriptor valid.
seg_rdy  in  1  server FSM accepts the descriptor.
seg_flags  out  6  {URG,ACK,PSH,RST,SYN,FIN}, bit0 = FIN.
seg_seq  out  32  sequence number.
seg_ack  out  32  acknowledgement number.
seg_win  out  16  window.
seg_len  out  16  payload byte count, saturating at 16'hFFFF.
seg_oversize  out  1  seg_len > MAX_PAYLOAD.
drop_cnt  out  16  dropped-segment counter, saturating.

Behaviour:
- Reset (rst high at clk edge):
  - state = IDLE; in_rdy = 0 for that cycle, then 1.
  - seg_vld = 0; all seg_* fields = 0; drop_cnt = 0.
  - A partial segment in progress is discarded and not counted.
- States: IDLE, HDR, OPT, PAY, OUT, DROP.
- in_rdy = 1 in every state except OUT, where it is 0.
- IDLE:
  - An accepted byte without in_sop is discarded silently and not counted.
  - An accepted byte with in_sop is stored as header byte 0, byte counter = 1, next state HDR.
  - sop && eop on the same byte: drop, next state IDLE.
- HDR: bytes 0..19 captured into fields.
  - Bytes 2-3 are the destination port.
  - Bytes 4-7 are seq, 8-11 are ack.
  - Byte 12 [7:4] is data offset (doff); byte 13 [5:0] is flags.
  - Bytes 14-15 are the window.
  - Checksum and urgent pointer are ignored (checksum is verified downstream of IP).
- End of HDR, on accepting byte 19:
  - If dst port != LOCAL_PORT or doff < 5 -> DROP. If in_eop is also set, drop immediately and go to IDLE.
  - Else if eop -> OUT with len = 0.
  - Else if doff > 5 -> OPT, skipping (doff-5)*4 bytes.
  - Else -> PAY.
- OPT: option bytes are skipped using a 6-bit counter.
  - eop before the options complete -> drop, next state IDLE.
  - Last option byte with eop -> OUT with len = 0.
  - Last option byte without eop -> PAY.
- PAY: each accepted byte increments len, saturating at 16'hFFFF. The byte with eop increments len, then next state OUT.
- Early end of segment: in_eop during HDR before byte 19 -> drop (truncated), next state IDLE.
- Segment abort: in_sop on any byte while in HDR, OPT, PAY or DROP:
  - The current segment is counted as a drop.
  - That byte starts a new segment as header byte 0 (state HDR).
- DROP: bytes are consumed until eop, then IDLE. drop_cnt increments exactly once per dropped segment.
- OUT:
  - seg_vld = 1 and all seg_* outputs are stable until seg_vld && seg_rdy.
  - On handshake: seg_vld = 0 next cycle, state IDLE.
  - Earliest next descriptor: 21 cycles later.
- Latency: seg_vld rises the cycle after the eop byte is accepted.
- seg_oversize is registered together with seg_len.
- Field capture is big-endian: the first byte is the MSB.
- drop_cnt holds at 16'hFFFF.
- seg_* outputs hold their last values while seg_vld = 0; consumers must only sample them when valid.

Decomposition:
- Package tcp_rx_decoder_pkg holds:
  - the state enum tcp_rx_state_t;
  - flag bit-index constants FLAG_FIN..FLAG_URG;
  - constants HDR_BYTES = 20 and MIN_DOFF = 5;
  - the packed struct tcp_seg_desc_t {flags, seq, ack, win, len, oversize}.
- The flag encoding in this package matches what the server FSM's operation selection decodes.
- Single module; no sub-module needed. The header byte shifter is inline.

Test Plan:
- Bare SYN: sop, dst = 80, seq = 0x11223344, ack = 0, doff = 5, flags = 0x02, win = 0xFFFF, eop on byte 19 -> seg_vld next cycle; flags = 6'b000010, seq = 0x11223344, len = 0, win = 0xFFFF, drop_cnt = 0.
- ACK + 100 payload bytes, doff = 8 (12 option bytes), seg_rdy held low 5 cycles -> len = 100, flags = 0x10; outputs stable 5 cycles; in_rdy = 0 throughout; handshake returns to IDLE.
- dst = 81 followed by a valid segment to port 80 -> first produces no descriptor and drop_cnt = 1; second is decoded normally.
- Truncation and abort:
  - eop on header byte 10 -> drop_cnt = 1, no seg_vld.
  - New sop mid-payload -> drop_cnt = 2, and the new segment decodes correctly.
  - doff = 4 -> dropped, drop_cnt = 3.
- Payload 1500 bytes -> len = 1500, seg_oversize = 1. Payload 70000 bytes -> len = 0xFFFF.
- rst asserted mid-payload, then bytes without sop, then a clean FIN segment:
  - Pre-sop bytes are ignored.
  - FIN descriptor emitted with flags = 0x01.
  - drop_cnt = 0.
